// File: rtl/temporal_pkg.sv
// Shared constants, state encoding and helpers for the temporal encoder
// and the other gamma-cycle blocks.
package temporal_pkg;

  localparam int DEF_GAMMA_CYCLE_WIDTH = 16;
  localparam int DEF_PULSE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PULSE,
    DONE
  } enc_state_t;

  function automatic int value_width(input int g);
    return (g > 1) ? $clog2(g) : 1;
  endfunction

endpackage

// File: rtl/gamma_counter.sv
// Gamma-cycle counter: cnt runs 0..G-1 while enabled, restarts at 0.
// Ports: aclk, grst (async, active-high), enable_i; cnt_o (current
// slot), wrap_o (next posedge starts a gamma cycle), gamma_rst_o.
module gamma_counter
  import temporal_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
  localparam int VW = value_width(GAMMA_CYCLE_WIDTH)
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          enable_i,
  output logic [VW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          gamma_rst_o
);

  localparam logic [VW-1:0] LAST = VW'(GAMMA_CYCLE_WIDTH - 1);

  logic          run_q;
  logic [VW-1:0] cnt_q;
  logic [VW-1:0] cnt_d;
  logic          gamma_rst_q;

  // First enabled edge after a stop restarts at 0 and counts as a wrap.
  always_comb begin
    cnt_d  = '0;
    wrap_o = 1'b0;
    if (enable_i) begin
      if (!run_q || cnt_q == LAST) begin
        wrap_o = 1'b1;
      end else begin
        cnt_d = cnt_q + VW'(1);
      end
    end
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      run_q       <= 1'b0;
      cnt_q       <= '0;
      gamma_rst_q <= 1'b0;
    end else begin
      run_q       <= enable_i;
      cnt_q       <= cnt_d;
      gamma_rst_q <= wrap_o;
    end
  end

  assign cnt_o       = cnt_q;
  assign gamma_rst_o = gamma_rst_q;

endmodule

// File: rtl/temporal_encoder.sv
// Encodes a value as a pulse at slot v of the following gamma cycle.
// Ports: aclk, grst (async, active-high), enable, in_valid/in_value/
// in_ready handshake, gamma_rst strobe, pulse, busy.
// Macro TEMPORAL_NULL_EN: v > G-PULSE_WIDTH means "never" (no pulse);
// otherwise such values are clamped to G-PULSE_WIDTH.
module temporal_encoder
  import temporal_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
  parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
  localparam int VALUE_WIDTH = value_width(GAMMA_CYCLE_WIDTH)
) (
  input  logic                   aclk,
  input  logic                   grst,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic [VALUE_WIDTH-1:0] in_value,
  output logic                   in_ready,
  output logic                   gamma_rst,
  output logic                   pulse,
  output logic                   busy
);

  localparam int VW = VALUE_WIDTH;
  localparam int VMAX = GAMMA_CYCLE_WIDTH - PULSE_WIDTH;
  localparam logic [VW:0] VMAX_W = (VW+1)'(VMAX);
  localparam logic [VW-1:0] VMAX_V = VW'(VMAX);
  localparam logic [VW:0] PW_W = (VW+1)'(PULSE_WIDTH);

  logic [VW-1:0] cnt;
  logic          wrap;

  gamma_counter #(
    .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
  ) u_cnt (
    .aclk       (aclk),
    .grst       (grst),
    .enable_i   (enable),
    .cnt_o      (cnt),
    .wrap_o     (wrap),
    .gamma_rst_o(gamma_rst)
  );

  logic          pend_valid_q, pend_valid_d;
  logic [VW-1:0] pend_v_q, pend_v_d;
  logic          act_valid_q, act_valid_d;
  logic [VW-1:0] act_v_q, act_v_d;
  logic          act_null_q, act_null_d;
  enc_state_t    state_q, state_d;
  logic          pulse_q, pulse_d;

  logic          hs;
  logic          pend_over;
  logic [VW:0]   act_w;
  logic [VW:0]   cnt_p1;

  assign hs        = in_valid & ~pend_valid_q;
  assign pend_over = {1'b0, pend_v_q} > VMAX_W;
  assign act_w     = {1'b0, act_v_q};
  assign cnt_p1    = {1'b0, cnt} + (VW+1)'(1);

  // A wrap empties pending; a handshake in the same cycle refills it.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_v_d     = pend_v_q;
    if (wrap) begin
      pend_valid_d = 1'b0;
    end
    if (hs) begin
      pend_valid_d = 1'b1;
      pend_v_d     = in_value;
    end
  end

  always_comb begin
    act_valid_d = act_valid_q;
    act_v_d     = act_v_q;
    act_null_d  = act_null_q;
    if (!enable) begin
      act_valid_d = 1'b0;
    end else if (wrap) begin
      act_valid_d = pend_valid_q;
      act_v_d     = pend_over ? VMAX_V : pend_v_q;
`ifdef TEMPORAL_NULL_EN
      act_null_d  = pend_over;
`else
      act_null_d  = 1'b0;
`endif
    end
  end

  // Transitions look one slot ahead so pulse can be a plain flop
  // that lines up with cnt, including v=0 alongside gamma_rst.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (wrap) begin
      if (!act_valid_d) begin
        state_d = IDLE;
      end else if (act_null_d) begin
        state_d = DONE;
      end else if (act_v_d == '0) begin
        state_d = PULSE;
      end else begin
        state_d = WAIT;
      end
    end else begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        WAIT:  if (cnt_p1 == act_w) state_d = PULSE;
        PULSE: if (cnt_p1 == act_w + PW_W) state_d = DONE;
        DONE:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    pulse_d = (state_d == PULSE);
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      pend_valid_q <= 1'b0;
      pend_v_q     <= '0;
      act_valid_q  <= 1'b0;
      act_v_q      <= '0;
      act_null_q   <= 1'b0;
      state_q      <= IDLE;
      pulse_q      <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_v_q     <= pend_v_d;
      act_valid_q  <= act_valid_d;
      act_v_q      <= act_v_d;
      act_null_q   <= act_null_d;
      state_q      <= state_d;
      pulse_q      <= pulse_d;
    end
  end

  assign in_ready = ~pend_valid_q;
  assign pulse    = pulse_q;
  assign busy     = (state_q == WAIT) || (state_q == PULSE);

endmodule

// File: tb/tb_temporal_encoder.sv
// Randomized bench for temporal_encoder against a slot-range model.
// Macro TEMPORAL_NULL_EN selects the "never" model for large values.
module tb_temporal_encoder;

  localparam int G  = 16;
  localparam int PW = 8;
  localparam int VW = 4;

  logic          aclk = 1'b0;
  logic          grst;
  logic          enable;
  logic          in_valid;
  logic [VW-1:0] in_value;
  logic          in_ready;
  logic          gamma_rst;
  logic          pulse;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  temporal_encoder #(
    .GAMMA_CYCLE_WIDTH(G),
    .PULSE_WIDTH(PW)
  ) dut (
    .aclk     (aclk),
    .grst     (grst),
    .enable   (enable),
    .in_valid (in_valid),
    .in_value (in_value),
    .in_ready (in_ready),
    .gamma_rst(gamma_rst),
    .pulse    (pulse),
    .busy     (busy)
  );

  always #5 aclk = ~aclk;

  // Model of the current cycle: running flag, slot, active and pending.
  bit m_run, m_av, m_null, m_pv;
  int m_cnt, m_v, m_pval;

  function automatic bit live();
    return m_run && m_av && !m_null;
  endfunction

  function automatic bit e_pulse();
    return live() && m_cnt >= m_v && m_cnt < m_v + PW;
  endfunction

  function automatic bit e_busy();
    return live() && m_cnt < m_v + PW;
  endfunction

  function automatic bit e_grst();
    return m_run && m_cnt == 0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_av = 0; m_null = 0; m_pv = 0;
    m_cnt = 0; m_v = 0; m_pval = 0;
  endtask

  task automatic set_active(input int val);
`ifdef TEMPORAL_NULL_EN
    m_null = val > G - PW;
    m_v    = val;
`else
    m_null = 0;
    m_v    = (val > G - PW) ? G - PW : val;
`endif
  endtask

  // Advance the model across one posedge using the driven inputs.
  task automatic model_advance();
    bit hs;
    int nv;
    hs = in_valid && !m_pv;
    nv = int'(in_value);
    if (!enable) begin
      m_run = 0; m_cnt = 0; m_av = 0;
    end else if (!m_run || m_cnt == G - 1) begin
      m_run = 1; m_cnt = 0;
      m_av  = m_pv;
      set_active(m_pval);
      m_pv  = 0;
    end else begin
      m_cnt++;
    end
    if (hs) begin
      m_pv = 1; m_pval = nv;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t (cnt %0d)",
               tag, obs, exp, $time, m_cnt);
    end
  endtask

  task automatic check_all();
    check("pulse", 32'(pulse), 32'(e_pulse()));
    check("busy", 32'(busy), 32'(e_busy()));
    check("gamma_rst", 32'(gamma_rst), 32'(e_grst()));
    check("in_ready", 32'(in_ready), 32'(!m_pv));
  endtask

  task automatic step(input logic en, input logic vld,
                      input logic [VW-1:0] val);
    @(negedge aclk);
    check_all();
    enable   = en;
    in_valid = vld;
    in_value = val;
    model_advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
  endtask

  initial begin
    int acc;
    grst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_value = '0;
    model_reset();
    repeat (2) @(negedge aclk);
    check("rst_pulse", 32'(pulse), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gamma", 32'(gamma_rst), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    grst = 1'b0;
    model_advance();

    // Single value, zero value, out-of-range value.
    step(1'b1, 1'b1, 4'd3);
    idle(40);
    step(1'b1, 1'b1, 4'd0);
    idle(40);
    step(1'b1, 1'b1, 4'd12);
    idle(40);

    // Back-to-back: 2 then 5 offered continuously.
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      logic vld;
      logic [VW-1:0] v;
      vld = acc < 2;
      v = (acc == 0) ? 4'd2 : 4'd5;
      if (vld && !m_pv) acc++;
      step(1'b1, vld, v);
    end
    check("b2b_accepts", 32'(acc), 32'd2);

    // Enable drop at cnt=5 mid-pulse with a pending value held.
    step(1'b1, 1'b1, 4'd2);
    for (int i = 0; i < 64; i++) begin
      if (m_cnt == 5 && e_pulse()) break;
      step(1'b1, !m_pv, 4'd7);
    end
    check("drop_at_5", 32'(m_cnt == 5 && e_pulse()), 32'd1);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("drop_pend", 32'(m_pv), 32'd1);
    idle(40);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 15) != 0), $urandom_range(0, 1) == 1,
           VW'($urandom_range(0, G - 1)));
    end

    // Asynchronous reset in the middle of a pulse.
    for (int i = 0; i < 64; i++) begin
      if (e_pulse()) break;
      step(1'b1, 1'b1, 4'd4);
    end
    @(posedge aclk);
    #2;
    check("pre_rst_pulse", 32'(pulse), 32'd1);
    grst = 1'b1;
    #1;
    check("arst_pulse", 32'(pulse), 32'd0);
    check("arst_gamma", 32'(gamma_rst), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge aclk);
    grst = 1'b0; enable = 1'b0; in_valid = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 4'd3);
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
